// File: rtl/color_gen_pkg.sv
// Shared definitions for the RGBW colour generator: mode codes, FSM states
// and a width-generic saturating add/subtract.
package color_gen_pkg;

   localparam logic [7:0] MODE_DIRECT        = 8'h21;
   localparam logic [7:0] MODE_DIRECT_SCALED = 8'h5A;
   localparam logic [7:0] MODE_HUE           = 8'hA4;

   localparam int NSEC = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HUE,
      ST_MIX,
      ST_MUL,
      ST_DONE
   } state_t;

   // Operands are zero-extended to 32 bits; the result clamps to [0, 2^w-1].
   function automatic logic [31:0] sat_addsub(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic        sub,
                                              input int unsigned w);
      logic [32:0] sum;
      logic [32:0] maxv;
      maxv = (33'd1 << w) - 33'd1;
      if (sub)
         sum = (b > a) ? 33'd0 : ({1'b0, a} - {1'b0, b});
      else
         sum = {1'b0, a} + {1'b0, b};
      if (sum > maxv)
         sum = maxv;
      return sum[31:0];
   endfunction

endpackage

// File: rtl/color_scale_mul.sv
// Sequential shift-add scaler: result = (c*lint + c) >> W, one lint bit per cycle.
// done and result are valid combinationally during the final step.
module color_scale_mul
   import color_gen_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] c,
   input  logic [W-1:0] lint,
   output logic         done,
   output logic [W-1:0] result
);

   localparam int AW = 2 * W + 1;
   localparam int BW = (W > 1) ? $clog2(W) : 1;

   logic          active;
   logic [W-1:0]  c_r;
   logic [W-1:0]  lint_r;
   logic [AW-1:0] acc;
   logic [AW-1:0] acc_next;
   logic [AW-1:0] addend;
   logic [BW-1:0] bit_idx;

   always_comb begin
      addend   = '0;
      if (lint_r[bit_idx])
         addend = AW'(c_r) << bit_idx;
      acc_next = acc + addend;
   end

   assign done   = active && (bit_idx == BW'(W - 1));
   assign result = W'(acc_next >> W);

   always_ff @(posedge clk) begin
      if (reset) begin
         active  <= 1'b0;
         c_r     <= '0;
         lint_r  <= '0;
         acc     <= '0;
         bit_idx <= '0;
      end else if (load) begin
         active  <= 1'b1;
         c_r     <= c;
         lint_r  <= lint;
         acc     <= AW'(c);
         bit_idx <= '0;
      end else if (active) begin
         acc <= acc_next;
         if (bit_idx == BW'(W - 1))
            active <= 1'b0;
         else
            bit_idx <= bit_idx + BW'(1);
      end
   end

endmodule

// File: rtl/color_gen_multi.sv
// RGBW colour generator: iterative hue wheel, white mix and per-channel
// intensity scaling feeding the PWM stage.
//
// state   | meaning
// IDLE    | waiting for start with a recognised mode
// HUE     | walking the index counter across the colour wheel
// MIX     | adding white into R/G/B with clamp, launching the scalers
// MUL     | four shift-add scalers running in parallel
// DONE    | outputs just updated; a new start is accepted here
module color_gen_multi
   import color_gen_pkg::*;
#(
   parameter int W    = 8,
   parameter int IDXW = 8,
   parameter int SEC  = 36,
   parameter int STEP = 7
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [7:0]      mode,
   input  logic [IDXW-1:0] color_idx,
   input  logic [W-1:0]    lint,
   input  logic [W-1:0]    white_in,
   input  logic [W-1:0]    red_in,
   input  logic [W-1:0]    green_in,
   input  logic [W-1:0]    blue_in,
   output logic [W-1:0]    red_out,
   output logic [W-1:0]    green_out,
   output logic [W-1:0]    blue_out,
   output logic [W-1:0]    white_out,
   output logic            busy,
   output logic            out_valid
);

   localparam logic [W-1:0] MAXV = '1;

   state_t          state;
   logic [IDXW-1:0] idx_r;
   logic [IDXW-1:0] cnt;
   logic [IDXW-1:0] pos;
   logic [2:0]      sector;
   logic [W-1:0]    up;
   logic [W-1:0]    up_next;
   logic [W-1:0]    dn;
   logic [W-1:0]    hue_r, hue_g, hue_b;
   logic [W-1:0]    r_c, g_c, b_c, w_c, lint_r;

   logic            idle_or_done;
   logic            mul_load;
   logic [W-1:0]    mul_c   [4];
   logic [W-1:0]    mul_res [4];
   logic [W-1:0]    mul_lint;
   logic [3:0]      mul_done;

   always_comb begin
      up_next = W'(sat_addsub(32'(up), 32'(STEP), 1'b0, W));
      dn      = W'(sat_addsub(32'(MAXV), 32'(up), 1'b1, W));
      hue_r   = MAXV;
      hue_g   = '0;
      hue_b   = '0;
      case (sector)
         3'd0: begin hue_r = MAXV; hue_g = '0;   hue_b = up;   end
         3'd1: begin hue_r = dn;   hue_g = '0;   hue_b = MAXV; end
         3'd2: begin hue_r = '0;   hue_g = up;   hue_b = MAXV; end
         3'd3: begin hue_r = '0;   hue_g = MAXV; hue_b = dn;   end
         3'd4: begin hue_r = up;   hue_g = MAXV; hue_b = '0;   end
         3'd5: begin hue_r = MAXV; hue_g = dn;   hue_b = '0;   end
         default: begin hue_r = MAXV; hue_g = '0; hue_b = '0; end
      endcase
   end

   assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);

   // Scalers load either straight from the inputs (direct-scaled start) or
   // from the white-mixed channel registers (end of MIX).
   always_comb begin
      mul_load = (idle_or_done && start && (mode == MODE_DIRECT_SCALED)) ||
                 (state == ST_MIX);
      if (state == ST_MIX) begin
         mul_c[0] = W'(sat_addsub(32'(r_c), 32'(w_c), 1'b0, W));
         mul_c[1] = W'(sat_addsub(32'(g_c), 32'(w_c), 1'b0, W));
         mul_c[2] = W'(sat_addsub(32'(b_c), 32'(w_c), 1'b0, W));
         mul_c[3] = w_c;
         mul_lint = lint_r;
      end else begin
         mul_c[0] = red_in;
         mul_c[1] = green_in;
         mul_c[2] = blue_in;
         mul_c[3] = white_in;
         mul_lint = lint;
      end
   end

   for (genvar ch = 0; ch < 4; ch++) begin : g_mul
      color_scale_mul #(.W(W)) u_mul (
         .clk    (clk),
         .reset  (reset),
         .load   (mul_load),
         .c      (mul_c[ch]),
         .lint   (mul_lint),
         .done   (mul_done[ch]),
         .result (mul_res[ch])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         red_out   <= '0;
         green_out <= '0;
         blue_out  <= '0;
         white_out <= '0;
         idx_r     <= '0;
         cnt       <= '0;
         pos       <= '0;
         sector    <= '0;
         up        <= '0;
         r_c       <= '0;
         g_c       <= '0;
         b_c       <= '0;
         w_c       <= '0;
         lint_r    <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               state <= ST_IDLE;
               if (start) begin
                  case (mode)
                     MODE_DIRECT: begin
                        red_out   <= red_in;
                        green_out <= green_in;
                        blue_out  <= blue_in;
                        white_out <= white_in;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                     end
                     MODE_DIRECT_SCALED: begin
                        r_c    <= red_in;
                        g_c    <= green_in;
                        b_c    <= blue_in;
                        w_c    <= white_in;
                        lint_r <= lint;
                        busy   <= 1'b1;
                        state  <= ST_MUL;
                     end
                     MODE_HUE: begin
                        idx_r  <= color_idx;
                        w_c    <= white_in;
                        lint_r <= lint;
                        cnt    <= '0;
                        pos    <= '0;
                        sector <= '0;
                        up     <= '0;
                        busy   <= 1'b1;
                        state  <= ST_HUE;
                     end
                     default: ;
                  endcase
               end
            end
            ST_HUE: begin
               if (cnt == idx_r) begin
                  r_c   <= hue_r;
                  g_c   <= hue_g;
                  b_c   <= hue_b;
                  state <= ST_MIX;
               end else begin
                  cnt <= cnt + IDXW'(1);
                  // Sector saturates past the last wheel segment so large
                  // indices land on the fixed red entry.
                  if (pos == IDXW'(SEC - 1)) begin
                     pos <= '0;
                     up  <= '0;
                     if (sector < 3'(NSEC))
                        sector <= sector + 3'd1;
                  end else begin
                     pos <= pos + IDXW'(1);
                     up  <= up_next;
                  end
               end
            end
            ST_MIX: state <= ST_MUL;
            ST_MUL: begin
               if (&mul_done) begin
                  red_out   <= mul_res[0];
                  green_out <= mul_res[1];
                  blue_out  <= mul_res[2];
                  white_out <= mul_res[3];
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_color_gen_multi.sv
// Scoreboard bench for color_gen_multi: expected outputs and arrival cycles are
// queued at each start and checked by a monitor when out_valid pulses.
module tb_color_gen_multi;
   import color_gen_pkg::*;

   localparam int W    = 8;
   localparam int IDXW = 8;
   localparam int SEC  = 36;
   localparam int STEP = 7;
   localparam int MX   = (1 << W) - 1;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic [7:0]      mode = 8'h00;
   logic [IDXW-1:0] color_idx = '0;
   logic [W-1:0]    lint = '0;
   logic [W-1:0]    white_in = '0, red_in = '0, green_in = '0, blue_in = '0;
   logic [W-1:0]    red_out, green_out, blue_out, white_out;
   logic            busy, out_valid;

   color_gen_multi #(.W(W), .IDXW(IDXW), .SEC(SEC), .STEP(STEP)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mode      (mode),
      .color_idx (color_idx),
      .lint      (lint),
      .white_in  (white_in),
      .red_in    (red_in),
      .green_in  (green_in),
      .blue_in   (blue_in),
      .red_out   (red_out),
      .green_out (green_out),
      .blue_out  (blue_out),
      .white_out (white_out),
      .busy      (busy),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [4*W-1:0] val;
      int             due;
   } exp_t;

   exp_t           sb[$];
   int             vectors = 0;
   int             miscompares = 0;
   logic [4*W-1:0] last_val = '0;

   function automatic logic [W-1:0] m_scale(input int c, input int l);
      return W'((c * (l + 1)) >> W);
   endfunction

   function automatic int m_mix(input int c, input int wv);
      return (c + wv > MX) ? MX : c + wv;
   endfunction

   function automatic logic [3*W-1:0] m_hue(input int idx);
      int s, p, u, d;
      logic [W-1:0] r, g, b;
      s = idx / SEC;
      p = idx % SEC;
      u = p * STEP;
      if (u > MX) u = MX;
      d = MX - u;
      case (s)
         0: begin r = W'(MX); g = '0;      b = W'(u);  end
         1: begin r = W'(d);  g = '0;      b = W'(MX); end
         2: begin r = '0;     g = W'(u);   b = W'(MX); end
         3: begin r = '0;     g = W'(MX);  b = W'(d);  end
         4: begin r = W'(u);  g = W'(MX);  b = '0;     end
         5: begin r = W'(MX); g = W'(d);   b = '0;     end
         default: begin r = W'(MX); g = '0; b = '0; end
      endcase
      return {r, g, b};
   endfunction

   // Drives a one-cycle start at the current negedge; returns one cycle later.
   task automatic issue(input logic [7:0] m, input int idx, input int l,
                        input int wv, input int rv, input int gv, input int bv,
                        input bit push);
      exp_t e;
      logic [3*W-1:0] h;
      int r, g, b;
      mode      = m;
      color_idx = IDXW'(idx);
      lint      = W'(l);
      white_in  = W'(wv);
      red_in    = W'(rv);
      green_in  = W'(gv);
      blue_in   = W'(bv);
      start     = 1'b1;
      e.val = '0;
      e.due = 0;
      if (m == MODE_DIRECT) begin
         e.val = {W'(rv), W'(gv), W'(bv), W'(wv)};
         e.due = cyc + 1;
      end else if (m == MODE_DIRECT_SCALED) begin
         e.val = {m_scale(rv, l), m_scale(gv, l), m_scale(bv, l), m_scale(wv, l)};
         e.due = cyc + W + 1;
      end else if (m == MODE_HUE) begin
         h = m_hue(idx);
         r = m_mix(int'(h[3*W-1:2*W]), wv);
         g = m_mix(int'(h[2*W-1:W]), wv);
         b = m_mix(int'(h[W-1:0]), wv);
         e.val = {m_scale(r, l), m_scale(g, l), m_scale(b, l), m_scale(wv, l)};
         e.due = cyc + idx + W + 3;
      end
      if (push && (m == MODE_DIRECT || m == MODE_DIRECT_SCALED || m == MODE_HUE))
         sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid === 1'b1) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_valid cyc=%0d out=%h", cyc,
                     {red_out, green_out, blue_out, white_out});
         end else begin
            e = sb.pop_front();
            if ({red_out, green_out, blue_out, white_out} !== e.val) begin
               miscompares++;
               $display("FAIL out_rgbw got=%h exp=%h", {red_out, green_out, blue_out, white_out}, e.val);
            end
            vectors++;
            if (cyc != e.due) begin
               miscompares++;
               $display("FAIL valid_cycle got=%0d exp=%0d", cyc, e.due);
            end
            last_val = e.val;
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      mode  = MODE_DIRECT;
      red_in = 8'd9; green_in = 8'd9; blue_in = 8'd9; white_in = 8'd9;
      repeat (2) begin
         @(negedge clk);
         vectors++;
         if ({red_out, green_out, blue_out, white_out, busy, out_valid} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=0",
                     {red_out, green_out, blue_out, white_out, busy, out_valid});
         end
      end
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      vectors++;
      if ({busy, out_valid} !== 2'b00 || {red_out, green_out, blue_out, white_out} !== '0) begin
         miscompares++;
         $display("FAIL start_in_reset got busy=%b valid=%b out=%h exp 0",
                  busy, out_valid, {red_out, green_out, blue_out, white_out});
      end
   endtask

   task automatic test_direct();
      issue(MODE_DIRECT, 0, 0, 40, 10, 20, 30, 1'b1);
      issue(MODE_DIRECT, 0, 0, 4, 1, 2, 3, 1'b1);
      wait_drain(20);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL direct_drain got=%0d pending exp=0", sb.size());
      end
      vectors++;
      if ({red_out, green_out, blue_out, white_out, out_valid} !== {8'd1, 8'd2, 8'd3, 8'd4, 1'b0}) begin
         miscompares++;
         $display("FAIL direct_hold got=%h exp=%h", {red_out, green_out, blue_out, white_out},
                  {8'd1, 8'd2, 8'd3, 8'd4});
      end
   endtask

   task automatic test_hue_idx0();
      issue(MODE_HUE, 0, 255, 0, 0, 0, 0, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         vectors++;
         if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL hue0_busy cycle N+%0d got=%b exp=1", k, busy);
         end
         @(negedge clk);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL hue0_busy_done got=%b exp=0", busy);
      end
      wait_drain(20);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL hue0_drain got=%0d pending exp=0", sb.size());
      end
   endtask

   task automatic test_hue_mix();
      issue(MODE_HUE, 40, 128, 50, 0, 0, 0, 1'b1);
      wait_drain(100);
      vectors++;
      if (last_val !== {8'd128, 8'd25, 8'd128, 8'd25} || sb.size() != 0) begin
         miscompares++;
         $display("FAIL hue_mix got=%h exp=%h", last_val, {8'd128, 8'd25, 8'd128, 8'd25});
      end
   endtask

   task automatic test_hue_edges();
      int idx_tab[6] = '{250, 35, 36, 215, 108, 179};
      foreach (idx_tab[i]) begin
         issue(MODE_HUE, idx_tab[i], 255, 0, 0, 0, 0, 1'b1);
         wait_drain(400);
      end
      for (int i = 0; i < 4; i++) begin
         issue(MODE_HUE, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), 0, 0, 0, 1'b1);
         wait_drain(400);
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL hue_edges_drain got=%0d pending exp=0", sb.size());
      end
   endtask

   task automatic test_direct_scaled();
      issue(MODE_DIRECT_SCALED, 0, 0, 255, 255, 255, 255, 1'b1);
      wait_drain(30);
      issue(MODE_DIRECT_SCALED, 0, 128, 40, 10, 20, 30, 1'b1);
      issue(MODE_DIRECT, 0, 0, 1, 1, 1, 1, 1'b0);
      start = 1'b0;
      wait_drain(30);
      issue(MODE_DIRECT_SCALED, 0, 255, 201, 7, 99, 254, 1'b1);
      wait_drain(30);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL dscaled_drain got=%0d pending exp=0", sb.size());
      end
   endtask

   task automatic test_busy_ignore();
      issue(MODE_HUE, 5, 200, 30, 0, 0, 0, 1'b1);
      mode = MODE_DIRECT;
      red_in = 8'd77; green_in = 8'd77; blue_in = 8'd77; white_in = 8'd77;
      start = 1'b1;
      repeat (6) @(negedge clk);
      start = 1'b0;
      wait_drain(40);
      vectors++;
      if (sb.size() != 0 || {red_out, green_out, blue_out, white_out} !== last_val) begin
         miscompares++;
         $display("FAIL busy_ignore got=%h exp=%h", {red_out, green_out, blue_out, white_out}, last_val);
      end
      mode  = 8'h00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || {red_out, green_out, blue_out, white_out} !== last_val) begin
         miscompares++;
         $display("FAIL unknown_mode got busy=%b out=%h exp busy=0 out=%h", busy,
                  {red_out, green_out, blue_out, white_out}, last_val);
      end
   endtask

   task automatic test_reset_mid_mul();
      issue(MODE_DIRECT_SCALED, 0, 200, 100, 100, 100, 100, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if ({red_out, green_out, blue_out, white_out, busy, out_valid} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_mul got=%h exp=0",
                  {red_out, green_out, blue_out, white_out, busy, out_valid});
      end
      reset = 1'b0;
      repeat (12) @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_idle got busy=%b exp=0", busy);
      end
      issue(MODE_DIRECT, 0, 0, 8, 5, 6, 7, 1'b1);
      wait_drain(10);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL post_reset_direct got=%0d pending exp=0", sb.size());
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_direct();
      test_hue_idx0();
      test_hue_mix();
      test_hue_edges();
      test_direct_scaled();
      test_busy_ignore();
      test_reset_mid_mul();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
